des_sbox_layer_pipe: RTL and testbench

//  Pipelined, parametrised DES substitution layer: LANES parallel 6->4 S-box lookups
//  (DES S-boxes FIRST_SBOX..FIRST_SBOX+LANES-1), registered over PIPE_STAGES stages.

---
 rtl/des_sbox_layer_pipe.sv | 109 ++++++++++
 tb/tb_des_sbox_layer_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_layer_pipe.sv
// des_sbox_layer_pipe
// LANES parallel DES S-box lookups (6 bits in, 4 bits out per lane) followed by
// PIPE_STAGES valid/ready register stages. Lane k uses S-box FIRST_SBOX+k.
// Bit 0 of every bus is the MSB: lane k input is in_data[6k:6k+5] and its
// result is out_data[4k:4k+3].
`timescale 1ns/1ps

module des_sbox_layer_pipe #(
    parameter int LANES       = 8,
    parameter int FIRST_SBOX  = 1,
    parameter int PIPE_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:6*LANES-1]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:4*LANES-1]   out_data
);

    localparam int OW = 4 * LANES;

    // Each S-box is 64 nibbles, row-major (row*16+col), entry 0 in the top nibble.
    localparam logic [255:0] SBOX_TABLE [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Reject configurations that would select a non-existent S-box or stage count.
    if (LANES < 1 || LANES > 8 || FIRST_SBOX < 1 || FIRST_SBOX + LANES - 1 > 8 ||
        PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : gen_bad_params
        $error("des_sbox_layer_pipe: illegal LANES/FIRST_SBOX/PIPE_STAGES");
    end

    // ------------------------------------------------------------------
    // Combinational substitution on the incoming word
    // ------------------------------------------------------------------
    logic [0:OW-1] lookup;

    for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
        localparam int BOX = FIRST_SBOX - 1 + gi;
        logic [5:0] b;
        logic [5:0] idx;

        assign b   = in_data[6*gi +: 6];
        // Outer bits pick the row, inner four bits pick the column.
        assign idx = {b[5], b[0], b[4:1]};
        // Shift the wanted nibble down to the bottom: 4*(63-idx) == {~idx, 2'b00}.
        assign lookup[4*gi +: 4] = 4'(SBOX_TABLE[BOX] >> {~idx, 2'b00});
    end

    // ------------------------------------------------------------------
    // Register stages with valid/ready; ready ripples back combinationally
    // so an empty stage always accepts (bubbles collapse).
    // ------------------------------------------------------------------
    logic [PIPE_STAGES-1:0] stage_valid;
    logic [0:OW-1]          stage_data [PIPE_STAGES];
    logic [PIPE_STAGES:0]   ready;

    assign ready[PIPE_STAGES] = out_ready;

    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : gen_stage
        logic          up_valid;
        logic [0:OW-1] up_data;
        logic          valid_reg;
        logic [0:OW-1] data_reg;

        if (gi == 0) begin : gen_head
            assign up_valid = in_valid;
            assign up_data  = lookup;
        end else begin : gen_body
            assign up_valid = stage_valid[gi-1];
            assign up_data  = stage_data[gi-1];
        end

        assign ready[gi]       = !valid_reg || ready[gi+1];
        assign stage_valid[gi] = valid_reg;
        assign stage_data[gi]  = data_reg;

        // Stage register: flush drops valids only, data is loaded only with a real word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (flush) begin
                valid_reg <= 1'b0;
            end else if (ready[gi]) begin
                valid_reg <= up_valid;
                if (up_valid) begin
                    data_reg <= up_data;
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = stage_valid[PIPE_STAGES-1];
    assign out_data  = stage_data[PIPE_STAGES-1];

endmodule

// File: tb/tb_des_sbox_layer_pipe.sv
// tb_des_sbox_layer_pipe
// Several configurations of the S-box layer share one stimulus stream. Each
// instance has a queue model (expected word + acceptance cycle) checked on
// every falling edge, plus directed literal checks from hand-computed values.
`timescale 1ns/1ps

module tb_des_sbox_layer_pipe;

    localparam int NI = 5;

    function automatic int lanes_of(int i);
        case (i)
            0: return 8;
            1: return 1;
            2: return 1;
            3: return 3;
            default: return 8;
        endcase
    endfunction

    function automatic int first_of(int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 8;
            3: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int stages_of(int i);
        case (i)
            0: return 1;
            1: return 1;
            2: return 1;
            3: return 3;
            default: return 2;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [0:47] in_data;

    logic [31:0] od_w [NI];
    logic        ov_w [NI];
    logic        ir_w [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Standard DES S-boxes, [box][row*16+col].
    int golden [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [3:0] sbox_ref(int box, logic [5:0] v);
        int row;
        int col;
        row = 2 * int'(v[5]) + int'(v[0]);
        col = int'(v[4:1]);
        return 4'(golden[box-1][row*16 + col]);
    endfunction

    // Right-aligned expected word: lane 0 ends up in the most significant nibble.
    function automatic logic [31:0] word_ref(int lanes, int first, logic [0:47] din);
        logic [31:0] w;
        logic [5:0]  v;
        w = '0;
        for (int k = 0; k < lanes; k++) begin
            v = din[6*k +: 6];
            w = (w << 4) | 32'(sbox_ref(first + k, v));
        end
        return w;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : gen_dut
        localparam int L = lanes_of(gi);
        localparam int F = first_of(gi);
        localparam int P = stages_of(gi);

        logic [0:4*L-1] od;
        logic           ov;
        logic           ir;

        des_sbox_layer_pipe #(
            .LANES(L), .FIRST_SBOX(F), .PIPE_STAGES(P)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .flush(flush),
            .in_valid(in_valid),
            .in_ready(ir),
            .in_data(in_data[0:6*L-1]),
            .out_valid(ov),
            .out_ready(out_ready),
            .out_data(od)
        );

        assign od_w[gi] = 32'(od);
        assign ov_w[gi] = ov;
        assign ir_w[gi] = ir;

        logic [31:0] qd [$];
        int          qt [$];
        int          cyc = 0;

        // Model and compare: words leave in acceptance order; the oldest word is
        // never blocked, so it is visible once it is P-1 cycles past its capture.
        always @(negedge clk) begin : model
            logic exp_ov;
            logic exp_ir;
            if (!rst_n) begin
                qd.delete();
                qt.delete();
                check($sformatf("inst%0d reset out_valid", gi), 32'(ov), 32'(1'b0));
                check($sformatf("inst%0d reset out_data", gi), od_w[gi], 32'h0);
                check($sformatf("inst%0d reset in_ready", gi), 32'(ir), 32'(1'b1));
            end else begin
                exp_ov = 1'b0;
                if (qd.size() > 0) exp_ov = (cyc - qt[0]) >= (P - 1);
                exp_ir = (qd.size() < P) || out_ready;
                check($sformatf("inst%0d out_valid", gi), 32'(ov), 32'(exp_ov));
                check($sformatf("inst%0d in_ready", gi), 32'(ir), 32'(exp_ir));
                if (exp_ov)
                    check($sformatf("inst%0d out_data", gi), od_w[gi], qd[0]);
                if (flush) begin
                    qd.delete();
                    qt.delete();
                end else begin
                    if (exp_ov && out_ready) begin
                        void'(qd.pop_front());
                        void'(qt.pop_front());
                    end
                    if (in_valid && exp_ir) begin
                        qd.push_back(word_ref(L, F, in_data));
                        qt.push_back(cyc + 1);
                    end
                end
                cyc++;
            end
        end

        // Asynchronous reset must clear the outputs without waiting for a clock.
        always @(negedge rst_n) begin
            #1;
            check($sformatf("inst%0d async reset out_valid", gi), 32'(ov), 32'(1'b0));
            check($sformatf("inst%0d async reset out_data", gi), od_w[gi], 32'h0);
        end
    end

    initial begin
        int          vals2 [4] = '{0, 1, 2, 63};
        int          exp2  [4] = '{15, 3, 1, 9};
        logic [63:0] r;
        logic        acc;
        int          sent;
        int          stalls;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the model against hand-read table entries.
        check("model S1[63]", 32'(sbox_ref(1, 6'd63)), 32'd13);
        check("model S8[0]", 32'(sbox_ref(8, 6'd0)), 32'd13);
        check("model S2[1]", 32'(sbox_ref(2, 6'd1)), 32'd3);
        check("model word zero", word_ref(8, 1, 48'h0), 32'hEFA72C4D);

        // Full layer on an all-zero word, one cycle latency.
        in_valid = 1'b1;
        in_data  = 48'h0;
        @(posedge clk); #1;
        check("t1 out_data", od_w[0], 32'hEFA72C4D);
        check("t1 out_valid", 32'(ov_w[0]), 32'(1'b1));

        // S2 single-lane stream, one result per cycle; S1/S8 corner entries.
        for (int i = 0; i < 4; i++) begin
            in_data = {8{6'(vals2[i])}};
            @(posedge clk); #1;
            check($sformatf("t2 S2 word%0d", i), od_w[1], 32'(exp2[i]));
            if (i == 0) check("t3 S8 000000", od_w[2], 32'd13);
            if (i == 3) check("t3 S1 111111", 32'(od_w[0][31:28]), 32'd13);
        end

        // Every 6-bit input through every S-box (all lanes carry the same value).
        for (int v = 0; v < 64; v++) begin
            in_data = {8{6'(v)}};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Ten random words against a 1,0,0,1 out_ready pattern.
        sent   = 0;
        stalls = 0;
        in_valid = 1'b1;
        r = {$urandom(), $urandom()};
        in_data = r[47:0];
        for (int c = 0; c < 200 && sent < 10; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
            acc = ir_w[3];
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 10) begin
                    r = {$urandom(), $urandom()};
                    in_data = r[47:0];
                end
            end else begin
                stalls++;
            end
        end
        check("t4 words sent", 32'(sent), 32'd10);
        check("t4 backpressure seen", 32'(stalls > 0), 32'd1);
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Fill the pipe while stalled, then flush with a word presented.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h123456789ABC;
        @(posedge clk); #1;
        in_data   = 48'hFEDCBA987654;
        @(posedge clk); #1;
        in_data   = 48'h0F0F0F0F0F0F;
        @(posedge clk); #1;
        flush     = 1'b1;
        in_data   = 48'hA5A5A5A5A5A5;
        @(posedge clk); #1;
        flush     = 1'b0;
        check("t5 out_valid after flush", 32'(ov_w[4]), 32'(1'b0));
        check("t5 in_ready after flush", 32'(ir_w[4]), 32'(1'b1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Flush while streaming: the flush-cycle word must be dropped even though accepted.
        in_valid = 1'b1;
        in_data  = 48'h111111111111;
        @(posedge clk); #1;
        in_data  = 48'h222222222222;
        @(posedge clk); #1;
        flush    = 1'b1;
        in_data  = 48'h333333333333;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_data  = 48'h444444444444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset with two words in flight in the two-stage pipe.
        in_valid = 1'b1;
        in_data  = 48'hDEADBEEF0123;
        @(posedge clk); #1;
        in_data  = 48'h456789ABCDEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6 out_valid in reset", 32'(ov_w[4]), 32'(1'b0));
        check("t6 out_data in reset", od_w[4], 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 48'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t6 first post-reset data", od_w[4], 32'hEFA72C4D);
        check("t6 first post-reset valid", 32'(ov_w[4]), 32'(1'b1));
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
